// File: rtl/vc_controller.sv
// Victim cache controller for a 4-way fully associative victim cache between L1 and pmem.
// Absorbs L1 evictions, services L1 read misses from its lines and writes back its own dirty victims.
module vc_controller #(
  parameter int ADDR_W   = 16,
  parameter int LINE_W   = 128,
  parameter int OFFSET_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              l1_read,
  input  logic              l1_write,
  input  logic [ADDR_W-1:0] l1_addr,
  input  logic [LINE_W-1:0] l1_wdata,
  input  logic              l1_dirty,
  output logic              l1_resp,
  output logic [LINE_W-1:0] l1_rdata,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_addr,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic [LINE_W-1:0] pmem_rdata,
  input  logic              pmem_resp,
  input  logic [1:0]        lru_replace,
  output logic              lru_write,
  output logic [1:0]        lru_way
);

  localparam int TAG_W = ADDR_W - OFFSET_W;

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] HIT_RESP  = 3'd1;
  localparam logic [2:0] MISS_READ = 3'd2;
  localparam logic [2:0] EVICT_WB  = 3'd3;
  localparam logic [2:0] INSTALL   = 3'd4;

  logic [2:0]        state;
  logic [3:0]        valid;
  logic [3:0]        dirty;
  logic [TAG_W-1:0]  tag_mem  [4];
  logic [LINE_W-1:0] data_mem [4];
  logic [1:0]        way;
  logic              wr_hit;

  logic [TAG_W-1:0]  req_tag;
  logic [3:0]        hit_vec;
  logic              hit_any;
  logic [1:0]        hit_way;
  logic [1:0]        victim;
  logic              unused_offset;

  // Priority encoder: lowest set bit of a 4-bit vector.
  function automatic logic [1:0] first_set(input logic [3:0] vec);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (vec[i]) begin
        idx = 2'(i);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

  assign req_tag       = l1_addr[ADDR_W-1:OFFSET_W];
  assign unused_offset = ^l1_addr[OFFSET_W-1:0];

  // Tag compare and replacement choice for the request presented in IDLE.
  always_comb begin
    hit_vec = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      hit_vec[i] = valid[i] && (tag_mem[i] == req_tag);
    end
    hit_any = |hit_vec;
    hit_way = first_set(hit_vec);
    if (&valid) begin
      victim = lru_replace;
    end else begin
      victim = first_set(~valid);
    end
  end

  // Controller FSM plus valid/dirty bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      valid  <= 4'b0000;
      dirty  <= 4'b0000;
      way    <= 2'd0;
      wr_hit <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (l1_write) begin
            way    <= hit_any ? hit_way : victim;
            wr_hit <= hit_any;
            // A miss may only overwrite a victim once its dirty data is safe in pmem.
            if (!hit_any && valid[victim] && dirty[victim]) begin
              state <= EVICT_WB;
            end else begin
              state <= INSTALL;
            end
          end else if (l1_read) begin
            way   <= hit_way;
            state <= hit_any ? HIT_RESP : MISS_READ;
          end else begin
            state <= IDLE;
          end
        end
        HIT_RESP: state <= IDLE;
        MISS_READ: begin
          if (pmem_resp) begin
            state <= IDLE;
          end else begin
            state <= MISS_READ;
          end
        end
        EVICT_WB: begin
          if (pmem_resp) begin
            state <= INSTALL;
          end else begin
            state <= EVICT_WB;
          end
        end
        INSTALL: begin
          valid[way] <= 1'b1;
          dirty[way] <= (wr_hit & dirty[way]) | l1_dirty;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Tag and data storage; intentionally not reset.
  always_ff @(posedge clk) begin
    if (!rst && (state == INSTALL)) begin
      tag_mem[way]  <= req_tag;
      data_mem[way] <= l1_wdata;
    end else begin
      tag_mem[way]  <= tag_mem[way];
      data_mem[way] <= data_mem[way];
    end
  end

  // Output decode from the current state; the miss path forwards pmem data directly.
  always_comb begin
    l1_resp    = 1'b0;
    l1_rdata   = '0;
    pmem_read  = 1'b0;
    pmem_write = 1'b0;
    pmem_addr  = '0;
    pmem_wdata = '0;
    lru_write  = 1'b0;
    lru_way    = way;
    case (state)
      HIT_RESP: begin
        l1_resp   = 1'b1;
        l1_rdata  = data_mem[way];
        lru_write = 1'b1;
      end
      MISS_READ: begin
        pmem_read = 1'b1;
        pmem_addr = {req_tag, {OFFSET_W{1'b0}}};
        if (pmem_resp) begin
          l1_resp  = 1'b1;
          l1_rdata = pmem_rdata;
        end else begin
          l1_resp  = 1'b0;
        end
      end
      EVICT_WB: begin
        pmem_write = 1'b1;
        pmem_addr  = {tag_mem[way], {OFFSET_W{1'b0}}};
        pmem_wdata = data_mem[way];
      end
      INSTALL: begin
        l1_resp   = 1'b1;
        lru_write = 1'b1;
      end
      default: begin
        l1_resp = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_vc_controller.sv
// Directed bench for vc_controller: a line-level cache model predicts every output cycle by cycle.
module tb_vc_controller;

  logic         clk = 1'b0;
  logic         rst;
  logic         l1_read, l1_write, l1_dirty;
  logic [15:0]  l1_addr;
  logic [127:0] l1_wdata;
  logic         l1_resp;
  logic [127:0] l1_rdata;
  logic         pmem_read, pmem_write;
  logic [15:0]  pmem_addr;
  logic [127:0] pmem_wdata, pmem_rdata;
  logic         pmem_resp;
  logic [1:0]   lru_replace;
  logic         lru_write;
  logic [1:0]   lru_way;

  vc_controller dut (
    .clk(clk), .rst(rst), .l1_read(l1_read), .l1_write(l1_write), .l1_addr(l1_addr),
    .l1_wdata(l1_wdata), .l1_dirty(l1_dirty), .l1_resp(l1_resp), .l1_rdata(l1_rdata),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_addr(pmem_addr),
    .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp),
    .lru_replace(lru_replace), .lru_write(lru_write), .lru_way(lru_way)
  );

  always #5 clk = ~clk;

  localparam logic [127:0] DA  = 128'hAAAA_0001_AAAA_0002_AAAA_0003_AAAA_0004;
  localparam logic [127:0] D1  = 128'h1111_1111_1111_1111_1111_1111_1111_1111;
  localparam logic [127:0] D2  = 128'h2222_2222_2222_2222_2222_2222_2222_2222;
  localparam logic [127:0] D3  = 128'h3333_3333_3333_3333_3333_3333_3333_3333;
  localparam logic [127:0] D4  = 128'h4444_4444_4444_4444_4444_4444_4444_4444;
  localparam logic [127:0] D2B = 128'h2B2B_0000_2B2B_0000_2B2B_0000_2B2B_0000;
  localparam logic [127:0] D9  = 128'h9999_1234_9999_5678_9999_9ABC_9999_DEF0;
  localparam logic [127:0] P7  = 128'h7777_CAFE_7777_BEEF_7777_F00D_7777_0123;
  localparam logic [127:0] P1  = 128'h0101_5555_0101_6666_0101_7777_0101_8888;

  int vectors = 0;
  int miscompares = 0;

  // Cache contents as the bench believes them to be.
  bit           m_valid [4];
  bit           m_dirty [4];
  logic [11:0]  m_tag   [4];
  logic [127:0] m_data  [4];

  // Expected outputs for the current cycle.
  bit           chk_en = 1'b0;
  bit           e_resp, e_rdata_chk, e_prd, e_pwr, e_lw;
  logic [127:0] e_rdata, e_pwdata;
  logic [15:0]  e_paddr;
  logic [1:0]   e_lway;

  logic [127:0] last_rdata, last_pwdata;
  logic [15:0]  last_pwaddr, last_praddr;
  logic [1:0]   last_lru_way;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, wanted %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic clear_exp();
    e_resp = 1'b0; e_rdata_chk = 1'b0; e_prd = 1'b0; e_pwr = 1'b0; e_lw = 1'b0;
    e_rdata = '0; e_pwdata = '0; e_paddr = '0; e_lway = 2'd0;
  endtask

  task automatic model_clear();
    for (int i = 0; i < 4; i++) begin
      m_valid[i] = 1'b0;
      m_dirty[i] = 1'b0;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Per-cycle comparison of every DUT output against the expectation of that cycle.
  always @(negedge clk) begin
    if (chk_en) begin
      check("l1_resp", {127'd0, l1_resp}, {127'd0, e_resp});
      check("pmem_read", {127'd0, pmem_read}, {127'd0, e_prd});
      check("pmem_write", {127'd0, pmem_write}, {127'd0, e_pwr});
      check("lru_write", {127'd0, lru_write}, {127'd0, e_lw});
      if (e_rdata_chk) check("l1_rdata", l1_rdata, e_rdata);
      if (e_prd || e_pwr) check("pmem_addr", {112'd0, pmem_addr}, {112'd0, e_paddr});
      if (e_pwr) check("pmem_wdata", pmem_wdata, e_pwdata);
      if (e_lw) check("lru_way", {126'd0, lru_way}, {126'd0, e_lway});
      if (l1_resp) last_rdata = l1_rdata;
      if (lru_write) last_lru_way = lru_way;
      if (pmem_write) begin
        last_pwaddr = pmem_addr;
        last_pwdata = pmem_wdata;
      end
      if (pmem_read) last_praddr = pmem_addr;
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    l1_read = 1'b0; l1_write = 1'b0; pmem_resp = 1'b0;
    clear_exp();
    step();
    step();
    rst = 1'b0;
    model_clear();
    step();
  endtask

  // One complete L1 transaction; entered and left at posedge+1 with requests idle.
  task automatic do_req(input bit wr, input logic [15:0] addr, input logic [127:0] wd,
                        input bit dty, input logic [1:0] lrep, input int lat,
                        input logic [127:0] prdata);
    int h;
    int t;
    h = -1;
    for (int i = 0; i < 4; i++) if (m_valid[i] && m_tag[i] == addr[15:4]) h = i;
    l1_read = !wr; l1_write = wr; l1_addr = addr; l1_wdata = wd; l1_dirty = dty;
    lru_replace = lrep;
    clear_exp();
    step();
    if (!wr && h >= 0) begin
      e_resp = 1'b1; e_rdata_chk = 1'b1; e_rdata = m_data[h]; e_lw = 1'b1; e_lway = 2'(h);
      step();
    end else if (!wr) begin
      for (int c = 1; c <= lat; c++) begin
        clear_exp();
        e_prd = 1'b1; e_paddr = {addr[15:4], 4'h0};
        if (c == lat) begin
          pmem_resp = 1'b1; pmem_rdata = prdata;
          e_resp = 1'b1; e_rdata_chk = 1'b1; e_rdata = prdata;
        end
        step();
        pmem_resp = 1'b0;
      end
    end else begin
      t = h;
      if (t < 0) for (int i = 3; i >= 0; i--) if (!m_valid[i]) t = i;
      if (t < 0) t = int'(lrep);
      if (h < 0 && m_valid[t] && m_dirty[t]) begin
        for (int c = 1; c <= lat; c++) begin
          clear_exp();
          e_pwr = 1'b1; e_paddr = {m_tag[t], 4'h0}; e_pwdata = m_data[t];
          if (c == lat) pmem_resp = 1'b1;
          step();
          pmem_resp = 1'b0;
        end
      end
      clear_exp();
      e_resp = 1'b1; e_lw = 1'b1; e_lway = 2'(t);
      step();
      m_dirty[t] = ((h >= 0) ? m_dirty[t] : 1'b0) | dty;
      m_valid[t] = 1'b1;
      m_tag[t]   = addr[15:4];
      m_data[t]  = wd;
    end
    l1_read = 1'b0; l1_write = 1'b0;
    clear_exp();
    step();
  endtask

  initial begin
    rst = 1'b1; l1_read = 1'b0; l1_write = 1'b0; l1_addr = 16'h0000; l1_wdata = '0;
    l1_dirty = 1'b0; pmem_rdata = '0; pmem_resp = 1'b0; lru_replace = 2'd0;
    clear_exp();
    step();
    chk_en = 1'b1;
    do_reset();

    // Eviction into an empty cache lands in way 0 with no pmem traffic.
    do_req(1'b1, 16'h1230, DA, 1'b1, 2'd3, 1, '0);
    check("lit_first_install_way", {126'd0, last_lru_way}, {126'd0, 2'd0});

    do_reset();
    do_req(1'b1, 16'h1000, D1, 1'b1, 2'd0, 1, '0);
    do_req(1'b1, 16'h2000, D2, 1'b1, 2'd0, 1, '0);
    do_req(1'b1, 16'h3000, D3, 1'b1, 2'd0, 1, '0);
    do_req(1'b1, 16'h4000, D4, 1'b1, 2'd0, 1, '0);
    check("lit_fourth_install_way", {126'd0, last_lru_way}, {126'd0, 2'd3});

    // Read hit ignores offset bits.
    do_req(1'b0, 16'h3004, '0, 1'b0, 2'd0, 1, '0);
    check("lit_hit_rdata", last_rdata, D3);
    check("lit_hit_lru_way", {126'd0, last_lru_way}, {126'd0, 2'd2});

    // Read miss: forwarded to pmem, not allocated (second read misses again).
    do_req(1'b0, 16'h7000, '0, 1'b0, 2'd0, 3, P7);
    check("lit_miss_addr", {112'd0, last_praddr}, {112'd0, 16'h7000});
    check("lit_miss_rdata", last_rdata, P7);
    do_req(1'b0, 16'h7008, '0, 1'b0, 2'd0, 1, D9);

    // Clean overwrite of a dirty resident line keeps it dirty.
    do_req(1'b1, 16'h2000, D2B, 1'b0, 2'd0, 1, '0);
    check("lit_overwrite_way", {126'd0, last_lru_way}, {126'd0, 2'd1});

    // Full and dirty: LRU way 1 written back, then reused.
    do_req(1'b1, 16'h9000, D9, 1'b1, 2'd1, 2, '0);
    check("lit_wb_addr", {112'd0, last_pwaddr}, {112'd0, 16'h2000});
    check("lit_wb_data", last_pwdata, D2B);
    check("lit_wb_install_way", {126'd0, last_lru_way}, {126'd0, 2'd1});
    do_req(1'b0, 16'h9000, '0, 1'b0, 2'd0, 1, '0);
    check("lit_reread_rdata", last_rdata, D9);

    // Stray pmem_resp in IDLE does nothing.
    clear_exp();
    pmem_resp = 1'b1;
    step();
    pmem_resp = 1'b0;
    step();

    // Reset while writing back way 3.
    l1_write = 1'b1; l1_addr = 16'hA000; l1_wdata = D1; l1_dirty = 1'b1; lru_replace = 2'd3;
    clear_exp();
    step();
    e_pwr = 1'b1; e_paddr = 16'h4000; e_pwdata = D4;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0; l1_write = 1'b0;
    model_clear();
    clear_exp();
    step();
    do_req(1'b0, 16'h1000, '0, 1'b0, 2'd0, 2, P1);
    check("lit_post_reset_miss_addr", {112'd0, last_praddr}, {112'd0, 16'h1000});
    do_req(1'b1, 16'h5000, D3, 1'b0, 2'd2, 1, '0);
    check("lit_post_reset_install_way", {126'd0, last_lru_way}, {126'd0, 2'd0});

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
